mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles an access waits for mem_ack (used only with MEM_TIMEOUT_EN).
REQ-002 clk  in  1  clock; all state updates occur on its rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 fetch_req  in  1  one-cycle pulse requesting a byte fetch at pc_addr.
REQ-005 rd_req  in  1  one-cycle pulse requesting a word read at mar_addr.
REQ-006 wr_req  in  1  one-cycle pulse requesting a word write of mdr_wdata at mar_addr.
REQ-007 pc_addr  in  32  PC register memory-side output.
REQ-008 mar_addr  in  32  MAR value.
REQ-009 mdr_wdata  in  32  MDR value to write.
REQ-010 mem_addr  out  32  address to main memory.
REQ-011 mem_wdata  out  32  write data to main memory.
REQ-012 mem_rd  out  1  memory read strobe, held until ack.
REQ-013 mem_wr  out  1  memory write strobe, held until ack.
REQ-014 mem_byte  out  1  high for a byte (fetch) access.
REQ-015 mem_ack  in  1  memory completion; read data valid in the same cycle.
REQ-016 mem_rdata  in  32  memory read data.
REQ-017 mbr_data  out  8  fetched byte, mem_rdata[7:0].
REQ-018 mbr_load  out  1  one-cycle MBR load strobe.
REQ-019 mdr_data  out  32  read word.
REQ-020 mdr_load  out  1  one-cycle MDR load strobe.
REQ-021 busy  out  1  high while any access is pending or in progress; the sequencer stalls on it.
REQ-022 err  out  1  sticky timeout flag.

Function
REQ-023 Each request SHALL set its pending flag and capture its address/data on the edge where it is sampled; a request of a type already pending SHALL be ignored.
REQ-024 If rd_req and wr_req are asserted in the same cycle, the write SHALL be captured and the read discarded.
REQ-025 The FSM SHALL have states IDLE, DATA_RD, DATA_WR, FETCH; the order of selection from pending flags SHALL be DATA_WR > DATA_RD > FETCH.
REQ-026 A request captured while in IDLE SHALL drive the memory strobe on the next cycle (one-cycle latency request-to-strobe).
REQ-027 In an access state, mem_addr, mem_wdata, mem_byte and the strobe SHALL remain stable until the cycle mem_ack=1.
REQ-028 On the ack edge, the FSM SHALL clear that pending flag and move directly to the next pending access, or to IDLE if none, with no bubble cycle.
REQ-029 A DATA_RD ack SHALL register mdr_data<=mem_rdata and pulse mdr_load for exactly the following cycle; a FETCH ack SHALL do the same for mbr_data<=mem_rdata[7:0] and mbr_load.
REQ-030 busy SHALL equal (state!=IDLE) OR any pending flag, registered combinationally from state, so it is high in the cycle after a request is captured.
REQ-031 mem_rd and mem_wr SHALL never be high together; both SHALL be low in IDLE.

Reset
REQ-032 reset SHALL return the FSM to IDLE; clear pending flags, counter and err; set mem_rd=mem_wr=mem_byte=0, mbr_load=mdr_load=0, mem_addr=mem_wdata=0, and mbr_data=mdr_data=0.
REQ-033 reset asserted mid-access SHALL abandon that access with no load strobe, and requests sampled during reset SHALL be discarded.

Configuration
REQ-034 With MEM_TIMEOUT_EN defined, a counter SHALL count the cycles spent in an access state; when it reaches TIMEOUT_CYCLES without an ack, that access SHALL be aborted (flag cleared, no load strobe), err SHALL be set until reset, and the FSM SHALL proceed per REQ-028.
REQ-035 Without MEM_TIMEOUT_EN, accesses SHALL wait for ack indefinitely and err SHALL be tied 0.

Verification
REQ-036 fetch_req with pc_addr=0x10, ack after 2 cycles, rdata=0x000000AB -> mem_rd=1 and mem_byte=1 at 0x10; mbr_data=0xAB; one mbr_load pulse; busy low afterward.
REQ-037 rd_req and fetch_req in the same cycle (mar=0x20, pc=0x04) -> read of 0x20 first, then fetch of 0x04 in the cycle after its ack; mdr_load precedes mbr_load.
REQ-038 rd_req and wr_req together with mar=0x30 and mdr=0xDEADBEEF -> only a write occurs (mem_wr=1, mem_wdata=0xDEADBEEF); no mdr_load.
REQ-039 reset asserted during DATA_RD before ack -> strobes drop the next cycle; no mdr_load; busy=0.
REQ-040 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> abort after 4 cycles; err=1 and stays set until reset; a pending fetch then proceeds.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch, data-read and data-write requests onto one memory port.
// Optional access timeout with sticky err is built when MEM_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] pc_addr,
  input  logic [31:0] mar_addr,
  input  logic [31:0] mdr_wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_byte,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  mbr_data,
  output logic        mbr_load,
  output logic [31:0] mdr_data,
  output logic        mdr_load,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA_RD = 2'd1,
    DATA_WR = 2'd2,
    FETCH   = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        pend_wr, pend_rd, pend_fetch;
  logic        nx_wr, nx_rd, nx_fetch;
  logic        acc_wr, acc_rd, acc_fetch;
  logic [31:0] wr_addr, wr_data, rd_addr, fetch_addr;
  logic [31:0] sel_addr, sel_wdata;
  logic        timeout_hit;
  logic        done;
  logic        go;

  // A read arriving together with a write is dropped; a type already pending is ignored.
  assign acc_wr    = wr_req & ~pend_wr;
  assign acc_rd    = rd_req & ~wr_req & ~pend_rd;
  assign acc_fetch = fetch_req & ~pend_fetch;

  assign done = (state != IDLE) && (mem_ack || timeout_hit);
  assign go   = (state == IDLE) || done;

  assign busy = (state != IDLE) | pend_wr | pend_rd | pend_fetch;

  // Pending view after this edge: finished access cleared, newly accepted requests added.
  assign nx_wr    = (pend_wr    & ~(done && state == DATA_WR)) | acc_wr;
  assign nx_rd    = (pend_rd    & ~(done && state == DATA_RD)) | acc_rd;
  assign nx_fetch = (pend_fetch & ~(done && state == FETCH))   | acc_fetch;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    sel_addr   = mem_addr;
    sel_wdata  = mem_wdata;
    if (go) begin
      if (nx_wr) begin
        next_state = DATA_WR;
        sel_addr   = acc_wr ? mar_addr  : wr_addr;
        sel_wdata  = acc_wr ? mdr_wdata : wr_data;
      end else if (nx_rd) begin
        next_state = DATA_RD;
        sel_addr   = acc_rd ? mar_addr : rd_addr;
      end else if (nx_fetch) begin
        next_state = FETCH;
        sel_addr   = acc_fetch ? pc_addr : fetch_addr;
      end else begin
        next_state = IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pend_wr    <= 1'b0;
      pend_rd    <= 1'b0;
      pend_fetch <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_addr    <= '0;
      fetch_addr <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_byte   <= 1'b0;
      mbr_data   <= '0;
      mbr_load   <= 1'b0;
      mdr_data   <= '0;
      mdr_load   <= 1'b0;
    end else begin
      pend_wr    <= nx_wr;
      pend_rd    <= nx_rd;
      pend_fetch <= nx_fetch;
      if (acc_wr) begin
        wr_addr <= mar_addr;
        wr_data <= mdr_wdata;
      end
      if (acc_rd)    rd_addr    <= mar_addr;
      if (acc_fetch) fetch_addr <= pc_addr;

      mdr_load <= (state == DATA_RD) && mem_ack;
      mbr_load <= (state == FETCH) && mem_ack;
      if ((state == DATA_RD) && mem_ack) mdr_data <= mem_rdata;
      if ((state == FETCH) && mem_ack)   mbr_data <= mem_rdata[7:0];

      // Strobes and address only change on a state transition, so they stay stable until ack.
      if (go) begin
        state    <= next_state;
        mem_rd   <= (next_state == DATA_RD) || (next_state == FETCH);
        mem_wr   <= (next_state == DATA_WR);
        mem_byte <= (next_state == FETCH);
        if (next_state != IDLE)    mem_addr  <= sel_addr;
        if (next_state == DATA_WR) mem_wdata <= sel_wdata;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  // Abort fires in the TIMEOUT_CYCLES-th strobe cycle unless ack arrives in that cycle.
  assign timeout_hit = (state != IDLE) && !mem_ack && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      wait_cnt <= go ? '0 : wait_cnt + 1'b1;
      if (timeout_hit) err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a slot/queue style reference model.
module tb_mem_port_arbiter;

  localparam int TB_TIMEOUT = 4;

  logic        clk;
  logic        reset;
  logic        fetch_req, rd_req, wr_req;
  logic [31:0] pc_addr, mar_addr, mdr_wdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rd, mem_wr, mem_byte;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [7:0]  mbr_data;
  logic        mbr_load;
  logic [31:0] mdr_data;
  logic        mdr_load;
  logic        busy, err;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .rd_req(rd_req), .wr_req(wr_req),
    .pc_addr(pc_addr), .mar_addr(mar_addr), .mdr_wdata(mdr_wdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_byte(mem_byte),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mbr_data(mbr_data), .mbr_load(mbr_load),
    .mdr_data(mdr_data), .mdr_load(mdr_load),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one slot per request kind, index = priority (0 write, 1 read, 2 fetch).
  typedef struct {
    bit          v;
    logic [31:0] a;
    logic [31:0] d;
  } slot_t;

  slot_t       slot [3];
  int          cur;      // slot being served, -1 when idle
  int          waited;
  logic [31:0] m_addr, m_wdata, m_mdr;
  logic [7:0]  m_mbr;
  bit          m_mdr_ld, m_mbr_ld, m_err;

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit f, input bit r, input bit w,
                            input logic [31:0] pc, input logic [31:0] mar, input logic [31:0] mdr,
                            input bit ack, input logic [31:0] rdata, input bit rst);
    bit acc [3];
    bit finished;
    if (rst) begin
      for (int i = 0; i < 3; i++) slot[i] = '{1'b0, 32'h0, 32'h0};
      cur = -1; waited = 0;
      m_addr = 0; m_wdata = 0; m_mdr = 0; m_mbr = 0;
      m_mdr_ld = 0; m_mbr_ld = 0; m_err = 0;
      return;
    end
    m_mdr_ld = 0;
    m_mbr_ld = 0;
    acc[0] = w && !slot[0].v;
    acc[1] = r && !w && !slot[1].v;
    acc[2] = f && !slot[2].v;
    finished = (cur < 0);
    if (cur >= 0) begin
      if (ack) begin
        if (cur == 1) begin m_mdr = rdata; m_mdr_ld = 1; end
        if (cur == 2) begin m_mbr = rdata[7:0]; m_mbr_ld = 1; end
        slot[cur].v = 0;
        finished = 1;
      end
`ifdef MEM_TIMEOUT_EN
      else begin
        waited++;
        if (waited >= TB_TIMEOUT) begin
          slot[cur].v = 0;
          m_err = 1;
          finished = 1;
        end
      end
`endif
    end
    if (acc[0]) slot[0] = '{1'b1, mar, mdr};
    if (acc[1]) slot[1] = '{1'b1, mar, 32'h0};
    if (acc[2]) slot[2] = '{1'b1, pc, 32'h0};
    if (finished) begin
      cur = -1;
      for (int i = 0; i < 3; i++) begin
        if (slot[i].v) begin
          cur = i;
          break;
        end
      end
      if (cur >= 0) begin
        waited = 0;
        m_addr = slot[cur].a;
        if (cur == 0) m_wdata = slot[0].d;
      end
    end
  endtask

  task automatic check_outputs();
    bit any_pend;
    any_pend = slot[0].v || slot[1].v || slot[2].v;
    check("mem_rd",    mem_rd,    (cur == 1) || (cur == 2));
    check("mem_wr",    mem_wr,    cur == 0);
    check("mem_byte",  mem_byte,  cur == 2);
    check("rd_wr_excl", mem_rd & mem_wr, 0);
    check("mem_addr",  mem_addr,  m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    check("busy",      busy,      (cur >= 0) || any_pend);
    check("mdr_load",  mdr_load,  m_mdr_ld);
    check("mbr_load",  mbr_load,  m_mbr_ld);
    check("mdr_data",  mdr_data,  m_mdr);
    check("mbr_data",  mbr_data,  m_mbr);
    check("err",       err,       m_err);
  endtask

  // Drive one cycle of inputs (we are at a negedge), advance the model, then check after the edge.
  task automatic cycle(input bit f, input bit r, input bit w,
                       input logic [31:0] pc, input logic [31:0] mar, input logic [31:0] mdr,
                       input bit ack, input logic [31:0] rdata, input bit rst);
    reset = rst; fetch_req = f; rd_req = r; wr_req = w;
    pc_addr = pc; mar_addr = mar; mdr_wdata = mdr;
    mem_ack = ack; mem_rdata = rdata;
    model_step(f, r, w, pc, mar, mdr, ack, rdata, rst);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input bit ack, input logic [31:0] rdata);
    cycle(0, 0, 0, 32'h0, 32'h0, 32'h0, ack, rdata, 0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1; fetch_req = 0; rd_req = 0; wr_req = 0;
    pc_addr = 0; mar_addr = 0; mdr_wdata = 0; mem_ack = 0; mem_rdata = 0;
    @(negedge clk);

    // Reset state
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_busy", busy, 0);

    // Single fetch, ack after two wait cycles
    cycle(1, 0, 0, 32'h10, 32'h0, 32'h0, 0, 0, 0);
    check("f_rd", mem_rd, 1);
    check("f_byte", mem_byte, 1);
    check("f_addr", mem_addr, 32'h10);
    idle(0, 0);
    idle(0, 0);
    idle(1, 32'h0000_00AB);
    check("f_mbr", mbr_data, 32'hAB);
    check("f_mbr_ld", mbr_load, 1);
    idle(0, 0);
    check("f_busy_after", busy, 0);
    check("f_mbr_ld_once", mbr_load, 0);

    // Read and fetch together: read first, fetch directly after its ack
    cycle(1, 1, 0, 32'h04, 32'h20, 32'h0, 0, 0, 0);
    check("rf_addr0", mem_addr, 32'h20);
    check("rf_byte0", mem_byte, 0);
    idle(1, 32'h1122_3344);
    check("rf_mdr_ld", mdr_load, 1);
    check("rf_mdr", mdr_data, 32'h1122_3344);
    check("rf_addr1", mem_addr, 32'h04);
    check("rf_byte1", mem_byte, 1);
    idle(1, 32'h0000_0055);
    check("rf_mbr_ld", mbr_load, 1);
    check("rf_mbr", mbr_data, 32'h55);
    idle(0, 0);

    // Read and write together: only the write happens
    cycle(0, 1, 1, 32'h0, 32'h30, 32'hDEAD_BEEF, 0, 0, 0);
    check("rw_wr", mem_wr, 1);
    check("rw_rd", mem_rd, 0);
    check("rw_wdata", mem_wdata, 32'hDEAD_BEEF);
    idle(1, 32'h9999_9999);
    check("rw_no_mdr", mdr_load, 0);
    idle(0, 0);
    check("rw_no_mdr2", mdr_load, 0);
    check("rw_busy", busy, 0);

    // Reset mid-read abandons it; a request sampled during reset is dropped
    cycle(0, 1, 0, 32'h0, 32'h40, 32'h0, 0, 0, 0);
    idle(0, 0);
    cycle(1, 0, 0, 32'h44, 32'h0, 32'h0, 0, 0, 1);
    check("rst_mid_rd", mem_rd, 0);
    check("rst_mid_busy", busy, 0);
    idle(1, 32'h1234_5678);
    check("rst_mid_mdr_ld", mdr_load, 0);

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after TB_TIMEOUT cycles, err sticks, pending fetch proceeds
    cycle(0, 1, 0, 32'h0, 32'h50, 32'h0, 0, 0, 0);
    cycle(1, 0, 0, 32'h60, 32'h0, 32'h0, 0, 0, 0);
    idle(0, 0);
    idle(0, 0);
    check("to_err_pre", err, 0);
    idle(0, 0);
    check("to_err", err, 1);
    check("to_fetch_addr", mem_addr, 32'h60);
    check("to_no_mdr", mdr_load, 0);
    idle(1, 32'h77);
    check("to_mbr_ld", mbr_load, 1);
    idle(0, 0);
    check("to_err_sticky", err, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("to_err_clr", err, 0);
`endif

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      bit f, r, w, a, rs;
      f  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 3) == 0);
      w  = ($urandom_range(0, 4) == 0);
      rs = ($urandom_range(0, 99) == 0);
      a  = ($urandom_range(0, 2) == 0);
      cycle(f, r, w, $urandom, $urandom, $urandom, a, $urandom, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
